// File: rtl/c432_query_engine_if.sv
// Query and response handshake channels between a host and the c432 query engine.
// The master drives queries and response backpressure; the slave is the engine.
interface c432_query_engine_if;
  logic        q_valid;
  logic        q_ready;
  logic [35:0] q_data;
  logic        r_valid;
  logic        r_ready;
  logic [35:0] r_pat;
  logic [6:0]  r_resp;

  modport master (
    output q_valid, q_data, r_ready,
    input  q_ready, r_valid, r_pat, r_resp
  );

  modport slave (
    input  q_valid, q_data, r_ready,
    output q_ready, r_valid, r_pat, r_resp
  );
endinterface

// File: rtl/c432_query_engine.sv
// Sequential query front-end for the combinational c432 benchmark: drives host or LFSR
// patterns onto pat_out, waits a settle time, and returns pattern + response.
module c432_query_engine #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  c432_query_engine_if.slave   qbus,
  input  logic                 batch_start,
  input  logic [35:0]          batch_seed,
  input  logic [CNT_W-1:0]     batch_len,
  output logic                 busy,
  output logic                 batch_done,
  output logic [35:0]          pat_out,
  input  logic [6:0]           dut_resp,
  output logic [CNT_W-1:0]     query_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  localparam logic [7:0] SettleInit = 8'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [35:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               batch_mode_q, batch_mode_d;
  logic               busy_q, busy_d;
  logic               batch_done_q, batch_done_d;
  logic [35:0]        pat_out_q, pat_out_d;
  logic               r_valid_q, r_valid_d;
  logic [35:0]        r_pat_q, r_pat_d;
  logic [6:0]         r_resp_q, r_resp_d;
  logic [CNT_W-1:0]   query_count_q, query_count_d;

  logic               q_ready;
  logic               resp_hs;
  logic [35:0]        seed_eff;
  logic [35:0]        lfsr_adv;
  logic [CNT_W-1:0]   rem_dec;

  // batch_start blocks the host channel in the same cycle so it always wins.
  assign q_ready  = (state_q == StIdle) & ~batch_mode_q & ~batch_start & rst_n;
  assign resp_hs  = r_valid_q & qbus.r_ready;
  assign seed_eff = (batch_seed == 36'h0) ? 36'h1 : batch_seed;
  assign lfsr_adv = {lfsr_q[34:0], lfsr_q[35] ^ lfsr_q[24]};
  assign rem_dec  = remaining_q - CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    remaining_d   = remaining_q;
    batch_mode_d  = batch_mode_q;
    batch_done_d  = 1'b0;
    pat_out_d     = pat_out_q;
    r_valid_d     = r_valid_q;
    r_pat_d       = r_pat_q;
    r_resp_d      = r_resp_q;
    query_count_d = query_count_q;

    unique case (state_q)
      StIdle: begin
        if (batch_start) begin
          lfsr_d      = seed_eff;
          remaining_d = batch_len;
          if (batch_len == '0) begin
            batch_done_d = 1'b1;
          end else begin
            batch_mode_d = 1'b1;
            pat_out_d    = seed_eff;
            cnt_d        = SettleInit;
            state_d      = StSettle;
          end
        end else if (qbus.q_valid && q_ready) begin
          pat_out_d = qbus.q_data;
          cnt_d     = SettleInit;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          r_resp_d  = dut_resp;
          r_pat_d   = pat_out_q;
          r_valid_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        if (resp_hs) begin
          r_valid_d = 1'b0;
          if (query_count_q != '1) begin
            query_count_d = query_count_q + CNT_W'(1);
          end
          if (batch_mode_q) begin
            lfsr_d      = lfsr_adv;
            remaining_d = rem_dec;
            if (rem_dec != '0) begin
              pat_out_d = lfsr_adv;
              cnt_d     = SettleInit;
              state_d   = StSettle;
            end else begin
              batch_mode_d = 1'b0;
              batch_done_d = 1'b1;
              state_d      = StIdle;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      lfsr_q        <= 36'h1;
      remaining_q   <= '0;
      batch_mode_q  <= 1'b0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      pat_out_q     <= 36'h0;
      r_valid_q     <= 1'b0;
      r_pat_q       <= 36'h0;
      r_resp_q      <= 7'h0;
      query_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      remaining_q   <= remaining_d;
      batch_mode_q  <= batch_mode_d;
      busy_q        <= busy_d;
      batch_done_q  <= batch_done_d;
      pat_out_q     <= pat_out_d;
      r_valid_q     <= r_valid_d;
      r_pat_q       <= r_pat_d;
      r_resp_q      <= r_resp_d;
      query_count_q <= query_count_d;
    end
  end

  assign qbus.q_ready  = q_ready;
  assign qbus.r_valid  = r_valid_q;
  assign qbus.r_pat    = r_pat_q;
  assign qbus.r_resp   = r_resp_q;
  assign busy          = busy_q;
  assign batch_done    = batch_done_q;
  assign pat_out       = pat_out_q;
  assign query_count   = query_count_q;

endmodule

// File: tb/tb_c432_query_engine.sv
// Scoreboard bench for c432_query_engine with a stub c432 (resp = pat[6:0] ^ 7'h55).
// Stimulus pushes expected responses; a negedge monitor pops and compares on handshakes.
module tb_c432_query_engine;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              batch_start;
  logic [35:0]       batch_seed;
  logic [CNT_W-1:0]  batch_len;
  logic              busy;
  logic              batch_done;
  logic [35:0]       pat_out;
  logic [6:0]        dut_resp;
  logic [CNT_W-1:0]  query_count;
  logic              rr_val, rr_rand_en, rr_rand;

  c432_query_engine_if qbus ();

  always #5 clk = ~clk;

  assign dut_resp     = pat_out[6:0] ^ 7'h55;
  assign qbus.r_ready = rr_rand_en ? rr_rand : rr_val;

  always @(posedge clk) rr_rand <= ($urandom_range(3, 0) != 0);

  c432_query_engine #(
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .qbus        (qbus),
    .batch_start (batch_start),
    .batch_seed  (batch_seed),
    .batch_len   (batch_len),
    .busy        (busy),
    .batch_done  (batch_done),
    .pat_out     (pat_out),
    .dut_resp    (dut_resp),
    .query_count (query_count)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  int               done_cnt = 0;
  logic [CNT_W-1:0] mdl_count = '0;
  logic [42:0]      exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [35:0] lfsr_next(input logic [35:0] s);
    logic [35:0] fb;
    fb = ((s >> 35) ^ (s >> 24)) & 36'h1;
    return (s << 1) | fb;
  endfunction

  // Monitor: one pop per response handshake, plus batch_done pulse and count model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (batch_done === 1'b1) done_cnt++;
      if (qbus.r_valid === 1'b1 && qbus.r_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(qbus.r_pat), 64'hDEAD);
        end else begin
          logic [42:0] e;
          e = exp_q.pop_front();
          check("resp_pat", 64'(qbus.r_pat), 64'(e[42:7]));
          check("resp_val", 64'(qbus.r_resp), 64'(e[6:0]));
        end
        if (mdl_count != '1) mdl_count = mdl_count + 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || qbus.r_valid) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) timeout("wait_idle");
    @(negedge clk);
  endtask

  task automatic host_query(input logic [35:0] d, output int lat);
    int k = 0;
    @(posedge clk);
    #1;
    qbus.q_valid = 1'b1;
    qbus.q_data  = d;
    @(negedge clk);
    while (!qbus.q_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) timeout("q_ready_wait");
    @(posedge clk);
    exp_q.push_back({d, 7'(d[6:0] ^ 7'h55)});
    #1;
    qbus.q_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!qbus.r_valid && lat < 100);
  endtask

  task automatic start_batch(input logic [35:0] seed, input logic [CNT_W-1:0] len,
                             input bit with_q);
    logic [35:0] s;
    @(posedge clk);
    #1;
    batch_start = 1'b1;
    batch_seed  = seed;
    batch_len   = len;
    if (with_q) begin
      qbus.q_valid = 1'b1;
      qbus.q_data  = 36'h9_8765_4321;
    end
    @(posedge clk);
    #1;
    batch_start  = 1'b0;
    qbus.q_valid = 1'b0;
    s = (seed == 36'h0) ? 36'h1 : seed;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({s, 7'(s[6:0] ^ 7'h55)});
      s = lfsr_next(s);
    end
  endtask

  task automatic run_batch(input logic [35:0] seed, input logic [CNT_W-1:0] len);
    int d0;
    d0 = done_cnt;
    start_batch(seed, len, 1'b0);
    wait_idle();
    check("batch_done_once", 64'(done_cnt - d0), 64'd1);
    check("count_after_batch", 64'(query_count), 64'(mdl_count));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(batch_done), 64'd0);
    check({tag, "_pat_out"}, 64'(pat_out), 64'd0);
    check({tag, "_r_valid"}, 64'(qbus.r_valid), 64'd0);
    check({tag, "_r_pat"}, 64'(qbus.r_pat), 64'd0);
    check({tag, "_r_resp"}, 64'(qbus.r_resp), 64'd0);
    check({tag, "_count"}, 64'(query_count), 64'd0);
    check({tag, "_q_ready"}, 64'(qbus.q_ready), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    logic [CNT_W-1:0] qc0;
    rst_n        = 1'b0;
    batch_start  = 1'b0;
    batch_seed   = 36'h0;
    batch_len    = '0;
    qbus.q_valid = 1'b0;
    qbus.q_data  = 36'h0;
    rr_val       = 1'b1;
    rr_rand_en   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("q_ready_after_reset", 64'(qbus.q_ready), 64'd1);

    host_query(36'h0_0000_000A, lat);
    check("host_latency", 64'(lat), 64'(SETTLE));
    check("host_r_pat", 64'(qbus.r_pat), 64'hA);
    check("host_r_resp", 64'(qbus.r_resp), 64'h5F);
    wait_idle();
    check("host_count", 64'(query_count), 64'd1);

    rr_val = 1'b0;
    host_query(36'h3, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_r_valid", 64'(qbus.r_valid), 64'd1);
      check("bp_r_resp", 64'(qbus.r_resp), 64'h56);
      check("bp_q_ready", 64'(qbus.q_ready), 64'd0);
    end
    rr_val = 1'b1;
    wait_idle();
    check("bp_count", 64'(query_count), 64'd2);
    check("bp_q_ready_idle", 64'(qbus.q_ready), 64'd1);

    qc0 = query_count;
    run_batch(36'h1, 8'd3);
    check("batch3_count_delta", 64'(query_count - qc0), 64'd3);

    start_batch(36'h55, 8'd0, 1'b0);
    check("len0_done_pulse", 64'(batch_done), 64'd1);
    check("len0_r_valid", 64'(qbus.r_valid), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("len0_done_low", 64'(batch_done), 64'd0);

    run_batch(36'h0, 8'd1);

    start_batch(36'h5, 8'd1, 1'b1);
    check("collide_pat_out", 64'(pat_out), 64'h5);
    wait_idle();
    check("collide_queue_empty", 64'(exp_q.size()), 64'd0);

    start_batch(36'h7, 8'd5, 1'b0);
    rst_n = 1'b0;
    d0    = done_cnt;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    mdl_count = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    check("midreset_no_resp", 64'(qbus.r_valid), 64'd0);
    host_query(36'h1_2345_6789, lat);
    wait_idle();
    check("post_reset_count", 64'(query_count), 64'd1);

    rr_rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 0) begin
        host_query({4'($urandom_range(15, 0)), 32'($urandom)}, lat);
        wait_idle();
        check("rand_host_count", 64'(query_count), 64'(mdl_count));
      end else begin
        run_batch(($urandom_range(3, 0) == 0) ? 36'h0 : {4'($urandom_range(15, 0)),
                  32'($urandom)}, CNT_W'($urandom_range(5, 1)));
      end
    end
    rr_rand_en = 1'b0;

    run_batch(36'hABC, 8'd255);
    host_query(36'h11, lat);
    wait_idle();
    host_query(36'h22, lat);
    wait_idle();
    check("sat_count", 64'(query_count), 64'hFF);
    check("sat_model", 64'(query_count), 64'(mdl_count));
    host_query(36'h33, lat);
    wait_idle();
    check("sat_hold", 64'(query_count), 64'hFF);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c432_query_engine.md
# c432_query_engine

Sequential query front-end for the combinational c432 interrupt-controller benchmark. It accepts 36-bit input patterns from a host or generates them from an internal LFSR. It drives each pattern onto the c432 primary inputs (G1GAT…G115GAT, in declaration order, LSB = G1GAT) and waits a programmable settle time. It then captures the 7 primary outputs (G223GAT…G432GAT, LSB = G223GAT) and returns pattern + response over a valid/ready channel. It sits directly upstream and downstream of the c432 instance and serves as the oracle-query path for attack and defense experiments.

## Interface
Parameters:
- SETTLE, 2: cycles between pattern drive and response sample; legal range 1–255.
- CNT_W, 16: width of the query counter and the batch length.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- q_valid  in  1  host query valid.
- q_ready  out  1  engine can accept a host query.
- q_data  in  36  host query pattern.
- batch_start  in  1  one-cycle pulse that starts LFSR batch mode.
- batch_seed  in  36  LFSR seed, sampled with batch_start.
- batch_len  in  CNT_W  number of batch queries, sampled with batch_start.
- busy  out  1  high in any state other than IDLE.
- batch_done  out  1  one-cycle pulse when a batch completes.
- pat_out  out  36  registered pattern to the c432 inputs.
- dut_resp  in  7  c432 outputs (combinational from pat_out).
- r_valid  out  1  response valid.
- r_ready  in  1  consumer ready.
- r_pat  out  36  pattern that produced r_resp.
- r_resp  out  7  captured c432 response.
- query_count  out  CNT_W  completed queries; saturating.

## Operation
- States: IDLE, SETTLE_WAIT, RESP.
- q_ready = (state==IDLE) & ~batch_mode & ~batch_start & rst_n. It is combinational.
- Host accept (q_valid & q_ready):
  - pat_out ← q_data.
  - Settle counter ← SETTLE-1.
  - Go to SETTLE_WAIT.
- SETTLE_WAIT:
  - Counter decrements once per cycle.
  - When the counter is 0: r_resp ← dut_resp, r_pat ← pat_out, r_valid ← 1, go to RESP.
- RESP:
  - r_valid, r_pat and r_resp hold stable until r_valid & r_ready.
  - On that handshake, query_count increments, saturating at all-ones.
  - Host mode: go to IDLE and clear r_valid.
- batch_start in IDLE:
  - batch_start wins over a simultaneous q_valid; that host query is not accepted.
  - lfsr ← batch_seed. A zero seed is replaced by 36'h1.
  - remaining ← batch_len.
  - If batch_len==0: pulse batch_done on the next cycle and stay IDLE.
  - Otherwise: batch_mode ← 1, pat_out ← lfsr value, go to SETTLE_WAIT.
- batch_start outside IDLE is ignored.
- LFSR step: lfsr ← {lfsr[34:0], lfsr[35]^lfsr[24]} (x^36+x^25+1). It advances once per response handshake in batch mode.
- Batch response handshake:
  - remaining decrements.
  - If the new value is nonzero: pat_out ← advanced LFSR, go to SETTLE_WAIT.
  - Otherwise: batch_mode ← 0, batch_done pulses on the next cycle, go to IDLE.
- pat_out changes only on a query start. It is otherwise held, so the c432 inputs are stable through SETTLE_WAIT and RESP.

## Timing
- Reset values: q_ready=0 (while rst_n low), busy=0, batch_done=0, pat_out=0, r_valid=0, r_pat=0, r_resp=0, query_count=0. Internal state goes to IDLE, with lfsr=1 and remaining=0.
- Reset mid-operation aborts the query or batch. No response or batch_done is emitted.
- Query latency, with the accept edge as edge 0:
  - pat_out is valid after edge 0.
  - dut_resp is sampled on edge SETTLE.
  - r_valid is high after edge SETTLE.
- Throughput:
  - Host mode: one query per SETTLE+2 cycles with r_ready tied high. The extra cycle is the IDLE re-accept.
  - Batch mode: one query per SETTLE+1 cycles, because it re-enters SETTLE_WAIT directly from RESP.
- Backpressure: no new query or LFSR advance happens while r_valid is high and r_ready is low.
- busy is registered. It is high from the cycle after accept or batch_start until the cycle after the final handshake.

## Test plan
- Use a bench stub for the c432 with dut_resp = pat_out[6:0] ^ 7'h55, SETTLE=2. Reset with rst_n low for 3 cycles → all outputs 0; q_ready=1 on the first cycle after release.
- Host query q_data=36'h0_0000_000A, r_ready=1 → r_valid high exactly 2 edges after accept, r_pat=36'hA, r_resp=7'h5F, query_count=1.
- Backpressure: query 36'h3, r_ready=0 for 10 cycles → r_valid held, r_resp=7'h56 stable, q_ready=0 throughout. Raise r_ready → one handshake, then IDLE.
- Batch with seed=36'h1, len=3, r_ready=1 → r_pat sequence 36'h1, 36'h2, 36'h4 and r_resp 7'h54, 7'h57, 7'h51. batch_done pulses once; query_count increases by 3.
- Batch with len=0 → batch_done pulse one cycle later, no r_valid. Batch with seed=0 → first r_pat=36'h1. batch_start together with q_valid → the host query is not accepted.
- Reset asserted mid-SETTLE_WAIT in a batch → all outputs 0 on the next edge, no batch_done. A host query after release completes normally. Saturation: preload via 2^CNT_W+1 queries → query_count stays at all-ones.
